// File: rtl/clock_display_scan_pkg.sv
// Shared types, segment codes and the binary-to-BCD helper for the HH:MM:SS scan display.
// Each field converts to a tens/units pair, or to two dash codes when it is out of range.
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] digit_idx_t;
    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } bcd_pair_t;

    localparam digit_idx_t IDX_FIRST = 3'd0;
    localparam digit_idx_t IDX_LAST  = 3'd5;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam bcd_t BCD_DASH = 4'hF;

    // Tens digit comes from a compare chain so no divider is synthesised.
    function automatic bcd_pair_t bin_to_bcd2(input logic [5:0] v, input logic [5:0] limit);
        bcd_pair_t  r;
        logic [5:0] rem;
        r   = '0;
        rem = v;
        if (v >= limit) begin
            r.tens  = BCD_DASH;
            r.units = BCD_DASH;
        end else begin
            if (v >= 6'd50) begin
                r.tens = 4'd5;
                rem    = v - 6'd50;
            end else if (v >= 6'd40) begin
                r.tens = 4'd4;
                rem    = v - 6'd40;
            end else if (v >= 6'd30) begin
                r.tens = 4'd3;
                rem    = v - 6'd30;
            end else if (v >= 6'd20) begin
                r.tens = 4'd2;
                rem    = v - 6'd20;
            end else if (v >= 6'd10) begin
                r.tens = 4'd1;
                rem    = v - 6'd10;
            end else begin
                r.tens = 4'd0;
                rem    = v;
            end
            r.units = rem[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD code to active-low 7-segment pattern; 0-9 are digits, 4'hF is a dash, all else blank.
// Purely combinational.
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:     seg = SEG_0;
            4'd1:     seg = SEG_1;
            4'd2:     seg = SEG_2;
            4'd3:     seg = SEG_3;
            4'd4:     seg = SEG_4;
            4'd5:     seg = SEG_5;
            4'd6:     seg = SEG_6;
            4'd7:     seg = SEG_7;
            4'd8:     seg = SEG_8;
            4'd9:     seg = SEG_9;
            BCD_DASH: seg = SEG_DASH;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed HH:MM:SS display driver with per-frame input snapshot and registered outputs.
// Optional CLKDISP_DP_BLINK_EN: separators follow snap_ss[0] so they blink with the seconds.
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] ss,
    input  logic [5:0] mm,
    input  logic [4:0] hh,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    digit_idx_t       idx_q;
    logic [5:0]       snap_ss;
    logic [5:0]       snap_mm;
    logic [4:0]       snap_hh;

    assign tick = (div_cnt == DIV_LAST);

    // Snapshot only at the frame wrap so one frame never mixes old and new time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx_q   <= IDX_FIRST;
            snap_ss <= '0;
            snap_mm <= '0;
            snap_hh <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                if (idx_q == IDX_LAST) begin
                    idx_q   <= IDX_FIRST;
                    snap_ss <= ss;
                    snap_mm <= mm;
                    snap_hh <= hh;
                end else begin
                    idx_q <= idx_q + 3'd1;
                end
            end
        end
    end

    bcd_pair_t ss_bcd;
    bcd_pair_t mm_bcd;
    bcd_pair_t hh_bcd;

    assign ss_bcd = bin_to_bcd2(snap_ss, 6'd60);
    assign mm_bcd = bin_to_bcd2(snap_mm, 6'd60);
    assign hh_bcd = bin_to_bcd2({1'b0, snap_hh}, 6'd24);

    logic [NUM_DIGITS-1:0][3:0] digit_code;
    logic [NUM_DIGITS-1:0][6:0] digit_seg;

    assign digit_code[0] = ss_bcd.units;
    assign digit_code[1] = ss_bcd.tens;
    assign digit_code[2] = mm_bcd.units;
    assign digit_code[3] = mm_bcd.tens;
    assign digit_code[4] = hh_bcd.units;
    assign digit_code[5] = hh_bcd.tens;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .code (digit_code[g]),
            .seg  (digit_seg[g])
        );
    end

    logic [6:0] seg_nxt;
    logic [5:0] an_nxt;
    logic       sep;
    logic       dp_nxt;

    always_comb begin
        seg_nxt = SEG_BLANK;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == digit_idx_t'(k)) seg_nxt = digit_seg[k];
        end
    end

    assign an_nxt = ~(6'd1 << idx_q);
    assign sep    = (idx_q == 3'd2) || (idx_q == 3'd4);

`ifdef CLKDISP_DP_BLINK_EN
    assign dp_nxt = ~sep | snap_ss[0];
`else
    assign dp_nxt = ~sep;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= 6'h3F;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan (SCAN_DIV=4) with a cycle-level arithmetic reference model.
module tb_clock_display_scan;

    localparam int DIV = 4;
    localparam int FRAME = DIV * 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] ss = '0;
    logic [5:0] mm = '0;
    logic [4:0] hh = '0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    clock_display_scan #(.SCAN_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ss    (ss),
        .mm    (mm),
        .hh    (hh),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

`ifdef CLKDISP_DP_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tab [10];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tab[d];
    endfunction

    // Reference: edges since reset release give the digit position; a field shows
    // its decimal digit or a dash when outside its legal range.
    function automatic logic [6:0] model_seg(input int idx, input int s, input int m, input int h);
        int v, lim;
        case (idx / 2)
            0: begin v = s; lim = 60; end
            1: begin v = m; lim = 60; end
            default: begin v = h; lim = 24; end
        endcase
        if (v >= lim) return 7'h3F;
        return (idx % 2 == 1) ? seg_of(v / 10) : seg_of(v % 10);
    endfunction

    int         m_cnt = 0;
    bit         started = 0;
    int         msnap_s = 0, msnap_m = 0, msnap_h = 0;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;

    always @(posedge clk) begin
        if (!rst_n) begin
            started = 1;
            m_cnt   = 0;
            msnap_s = 0; msnap_m = 0; msnap_h = 0;
            e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
        end else if (started) begin
            int pidx;
            pidx  = (m_cnt / DIV) % 6;
            e_an  = 6'h3F & ~(6'd1 << pidx);
            e_seg = model_seg(pidx, msnap_s, msnap_m, msnap_h);
            if (pidx == 2 || pidx == 4) e_dp = BLINK ? 1'(msnap_s % 2) : 1'b0;
            else e_dp = 1'b1;
            m_cnt++;
            if (m_cnt % FRAME == 0) begin
                msnap_s = int'(ss); msnap_m = int'(mm); msnap_h = int'(hh);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_an",  {2'b0, an},  {2'b0, e_an});
            chk("model_seg", {1'b0, seg}, {1'b0, e_seg});
            chk("model_dp",  {7'b0, dp},  {7'b0, e_dp});
        end
    end

    // Advance to the point just after the edge that makes m_cnt == t.
    task automatic goto(input int t);
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (m_cnt != t && guard < 500);
        if (m_cnt != t) begin
            n_chk++;
            $display("FAIL goto_timeout: got m=%0d expected m=%0d", m_cnt, t);
        end
    endtask

    initial begin
        logic [6:0] t2_seg [6];
        logic [5:0] t2_an  [6];
        t2_seg = '{7'h00, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24};
        t2_an  = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

        // 1: reset and release
        hh = 5'd23; mm = 6'd59; ss = 6'd58;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an",  {2'b0, an},  8'h3F);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_dp",  {7'b0, dp},  8'h01);
        rst_n = 1'b1;
        goto(1);
        chk("rel_an",  {2'b0, an},  8'h3E);
        chk("rel_seg", {1'b0, seg}, 8'h40);

        // 2: 23:59:58 in the second frame
        for (int k = 0; k < 6; k++) begin
            goto(25 + 4 * k);
            chk("t2_seg", {1'b0, seg}, {1'b0, t2_seg[k]});
            chk("t2_an",  {2'b0, an},  {2'b0, t2_an[k]});
            if (k == 0) chk("t2_dp0", {7'b0, dp}, 8'h01);
            if (k == 2) chk("t2_dp2", {7'b0, dp}, 8'h00);
        end
        goto(48);
        chk("t2_hold", {1'b0, seg}, 8'h24);

        // 3: input change mid-frame is ignored until the wrap
        hh = 5'd12; mm = 6'd34; ss = 6'd56;
        goto(73);
        chk("t3_idx0", {1'b0, seg}, 8'h02);
        goto(81);
        chk("t3_idx2", {1'b0, seg}, 8'h19);
        hh = 5'd1; mm = 6'd2; ss = 6'd3;
        goto(85);
        chk("t3_idx3", {1'b0, seg}, 8'h30);
        goto(89);
        chk("t3_idx4", {1'b0, seg}, 8'h24);
        goto(93);
        chk("t3_idx5", {1'b0, seg}, 8'h79);
        goto(97);
        chk("t3_next", {1'b0, seg}, 8'h30);

        // 4: out-of-range minutes and hours show dashes
        hh = 5'd24; mm = 6'd60; ss = 6'd7;
        goto(121);
        chk("t4_idx0", {1'b0, seg}, 8'h78);
        goto(125);
        chk("t4_idx1", {1'b0, seg}, 8'h40);
        for (int k = 2; k < 6; k++) begin
            goto(121 + 4 * k);
            chk("t4_dash", {1'b0, seg}, 8'h3F);
        end

        // 5: reset while idx=3
        goto(157);
        chk("t5_pre_an", {2'b0, an}, 8'h37);
        hh = 5'd0; mm = 6'd0; ss = 6'd59;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_an",  {2'b0, an},  8'h3F);
        chk("t5_seg", {1'b0, seg}, 8'h7F);
        chk("t5_dp",  {7'b0, dp},  8'h01);
        rst_n = 1'b1;
        goto(1);
        chk("t5_an1",  {2'b0, an},  8'h3E);
        chk("t5_seg1", {1'b0, seg}, 8'h40);
        goto(4);
        chk("t5_an4", {2'b0, an}, 8'h3E);
        goto(5);
        chk("t5_an5", {2'b0, an}, 8'h3D);

        // 6: decimal points with snap_ss=59
        goto(25);
        chk("t6_seg", {1'b0, seg}, 8'h10);
        goto(33);
        chk("t6_dp2", {7'b0, dp}, BLINK ? 8'h01 : 8'h00);
        goto(37);
        chk("t6_dp3", {7'b0, dp}, 8'h01);
        goto(41);
        chk("t6_dp4", {7'b0, dp}, BLINK ? 8'h01 : 8'h00);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
